// File: rtl/mips_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_alu_pkg
//  Description : Shared definitions for the multi-cycle MIPS ALU:
//                operation codes, controller state encoding and a helper
//                that identifies the iterative operations.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_alu_pkg;

    // ALU control codes, compatible with the single-cycle ALU encoding
    localparam int unsigned ALU_AND   = 0;
    localparam int unsigned ALU_OR    = 1;
    localparam int unsigned ALU_ADD   = 2;
    localparam int unsigned ALU_SUB   = 6;
    localparam int unsigned ALU_SLT   = 7;
    localparam int unsigned ALU_SLTU  = 8;
    localparam int unsigned ALU_NOR   = 12;
    localparam int unsigned ALU_MULTU = 13;
    localparam int unsigned ALU_DIVU  = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // True for op codes that use the shared iterative datapath
    function automatic logic is_multicycle(input int unsigned ctl);
        return (ctl == ALU_MULTU) || (ctl == ALU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_muldiv_iter
//  Description : Iterative unsigned multiplier (shift-add) and restoring
//                divider sharing one accumulator/shift register pair.
//                One iteration per cycle, exactly WIDTH iterations.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n    clock, asynchronous active-low reset
//    start         load operands and begin an operation
//    mode_div      sampled with start: 1 = divide, 0 = multiply
//    a, b          operands (multiplicand/multiplier or dividend/divisor)
//    done          high during the final iteration cycle
//    hi_nxt        value the high register takes at the end of this cycle
//                  (product high word / remainder once done)
//    lo_nxt        same for the low register (product low word / quotient)
// ============================================================================
module mips_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // product high word / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;     // multiplier bits / dividend-quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is
        // set, then shift the {acc, lo} pair right by one, carry included.
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);

        // Restoring step: bring the next dividend bit into the remainder and
        // keep the subtraction only if it does not go negative.
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_fits  = ~div_diff[WIDTH];

        if (div_q) begin
            step_hi = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done   = busy_q && (cnt_q == CNT_LAST);
    assign hi_nxt = step_hi;
    assign lo_nxt = step_lo;

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        lo_d   = lo_q;
        opb_d  = opb_q;
        if (start) begin
            busy_d = 1'b1;
            div_d  = mode_div;
            cnt_d  = '0;
            acc_d  = '0;
            lo_d   = a;
            opb_d  = b;
        end else if (busy_q) begin
            acc_d = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opb_q  <= opb_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : mips_alu_mc
//  Description : Multi-cycle MIPS ALU with valid/ready handshakes. Logic,
//                add/sub, set-less-than ops complete in one cycle; MULTU and
//                DIVU run WIDTH iterations in mips_muldiv_iter.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n           clock, asynchronous active-low reset
//    in_valid/in_ready    operation handshake (in_ready only in IDLE)
//    alu_ctl, a, b        operation code and operands
//    out_valid/out_ready  result handshake
//    result               primary result (LO for mul, quotient for div)
//    hi                   mul high word / div remainder, else 0
//    zero, ovf, div0, bad_op  status flags, valid with out_valid
// ============================================================================
module mips_alu_mc #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTL_W-1:0] alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             div0,
    output logic             bad_op
);

    import mips_alu_pkg::*;

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             div0_q, div0_d;
    logic             bad_op_q, bad_op_d;

    logic [31:0]      ctl_ext;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_div0;
    logic             sc_bad;
    logic             launch;

    logic             iter_done;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign ctl_ext = 32'(alu_ctl);
    assign sum     = a + b;
    assign diff    = a - b;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the operands presented at accept
    // ------------------------------------------------------------------
    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_ovf    = 1'b0;
        sc_div0   = 1'b0;
        sc_bad    = 1'b0;
        case (ctl_ext)
            ALU_AND:  sc_result = a & b;
            ALU_OR:   sc_result = a | b;
            ALU_ADD: begin
                sc_result = sum;
                // same-sign operands producing an opposite-sign sum
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result = diff;
                // opposite-sign operands where the sign flips away from a
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_NOR:  sc_result = ~(a | b);
            ALU_MULTU: begin
                // produced by the iterative datapath
            end
            ALU_DIVU: begin
                // divide-by-zero short-cuts the iteration with a fixed answer
                if (b == '0) begin
                    sc_result = '1;
                    sc_hi     = a;
                    sc_div0   = 1'b1;
                end
            end
            default:  sc_bad = 1'b1;
        endcase
    end

    assign launch = in_valid && (state_q == IDLE) && is_multicycle(ctl_ext) && !sc_div0;

    mips_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (launch),
        .mode_div (ctl_ext == ALU_DIVU),
        .a        (a),
        .b        (b),
        .done     (iter_done),
        .hi_nxt   (iter_hi),
        .lo_nxt   (iter_lo)
    );

    // ------------------------------------------------------------------
    // Controller and output registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        div0_d   = div0_q;
        bad_op_d = bad_op_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (launch) begin
                        state_d = BUSY;
                    end else begin
                        state_d  = DONE;
                        result_d = sc_result;
                        hi_d     = sc_hi;
                        zero_d   = (sc_result == '0);
                        ovf_d    = sc_ovf;
                        div0_d   = sc_div0;
                        bad_op_d = sc_bad;
                    end
                end
            end
            BUSY: begin
                // capture the final iteration's outputs on the same edge the
                // iterator writes them, so DONE follows WIDTH busy cycles
                if (iter_done) begin
                    state_d  = DONE;
                    result_d = iter_lo;
                    hi_d     = iter_hi;
                    zero_d   = (iter_lo == '0);
                    ovf_d    = 1'b0;
                    div0_d   = 1'b0;
                    bad_op_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d  = IDLE;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    div0_d   = 1'b0;
                    bad_op_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
            bad_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
            bad_op_q <= bad_op_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign div0      = div0_q;
    assign bad_op    = bad_op_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_alu_mc
//  Description : Directed self-checking bench for mips_alu_mc (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        div0;
    logic        bad_op;

    int n_checks = 0;
    int n_pass   = 0;

    mips_alu_mc #(
        .WIDTH (32),
        .CTL_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .ovf       (ovf),
        .div0      (div0),
        .bad_op    (bad_op)
    );

    always #5 clk = ~clk;

    // Present one operation for the accept edge, then scramble the inputs so
    // any use of live (uncaptured) operands shows up in the results.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] op_a, input logic [31:0] op_b);
        alu_ctl  = ctl;
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0000_0000;
    endtask

    // Cycles counted from the accept edge (1 = visible right after it).
    task automatic wait_valid(output int cycles, output bit saw_ready);
        cycles    = 1;
        saw_ready = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctl = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if ({result, hi} !== 64'h0) $display("FAIL reset result/hi: got %h/%h want 0/0", result, hi); else n_pass++;
        n_checks++; if ({zero, ovf, div0, bad_op} !== 4'b0000) $display("FAIL reset flags: got %b want 0000", {zero, ovf, div0, bad_op}); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        int cyc; bit rdy;
        issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_valid(cyc, rdy);
        n_checks++; if (cyc != 1) $display("FAIL add latency: got %0d want 1", cyc); else n_pass++;
        n_checks++; if (result !== 32'h8000_0000) $display("FAIL add result: got %h want 80000000", result); else n_pass++;
        n_checks++; if ({ovf, zero} !== 2'b10) $display("FAIL add ovf/zero: got %b want 10", {ovf, zero}); else n_pass++;
        drain();
        issue(4'd6, 32'd5, 32'd5);
        wait_valid(cyc, rdy);
        n_checks++; if (result !== 32'h0) $display("FAIL sub_eq result: got %h want 0", result); else n_pass++;
        n_checks++; if ({ovf, zero} !== 2'b01) $display("FAIL sub_eq ovf/zero: got %b want 01", {ovf, zero}); else n_pass++;
        drain();
        issue(4'd6, 32'h8000_0000, 32'h0000_0001);
        wait_valid(cyc, rdy);
        n_checks++; if (result !== 32'h7FFF_FFFF) $display("FAIL sub_ovf result: got %h want 7fffffff", result); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL sub_ovf ovf: got %b want 1", ovf); else n_pass++;
        drain();
    endtask

    task automatic test_compare_logic();
        int cyc; bit rdy;
        issue(4'd7, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_valid(cyc, rdy);
        n_checks++; if (result !== 32'h1) $display("FAIL slt result: got %h want 1", result); else n_pass++;
        drain();
        issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_valid(cyc, rdy);
        n_checks++; if (result !== 32'h0) $display("FAIL sltu result: got %h want 0", result); else n_pass++;
        drain();
        issue(4'd12, 32'h0, 32'h0);
        wait_valid(cyc, rdy);
        n_checks++; if (result !== 32'hFFFF_FFFF) $display("FAIL nor result: got %h want ffffffff", result); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL nor hi: got %h want 0", hi); else n_pass++;
        drain();
    endtask

    task automatic test_bad_op();
        int cyc; bit rdy;
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid(cyc, rdy);
        n_checks++; if (cyc != 1) $display("FAIL bad_op latency: got %0d want 1", cyc); else n_pass++;
        n_checks++; if (bad_op !== 1'b1) $display("FAIL bad_op flag: got %b want 1", bad_op); else n_pass++;
        n_checks++; if ({result, hi} !== 64'h0) $display("FAIL bad_op result/hi: got %h/%h want 0/0", result, hi); else n_pass++;
        drain();
    endtask

    task automatic test_multu();
        int cyc; bit rdy;
        issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(cyc, rdy);
        n_checks++; if (cyc != 33) $display("FAIL multu latency: got %0d want 33", cyc); else n_pass++;
        n_checks++; if (rdy !== 1'b0) $display("FAIL multu in_ready while busy: got %b want 0", rdy); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu hi: got %h want fffffffe", hi); else n_pass++;
        n_checks++; if (result !== 32'h0000_0001) $display("FAIL multu lo: got %h want 00000001", result); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL multu in_ready in done: got %b want 0", in_ready); else n_pass++;
        drain();
        // product with an all-zero low word: zero follows result only
        issue(4'd13, 32'h0001_0000, 32'h0001_0000);
        wait_valid(cyc, rdy);
        n_checks++; if ({hi, result} !== 64'h0000_0001_0000_0000) $display("FAIL multu_2^32 hi/lo: got %h/%h want 00000001/00000000", hi, result); else n_pass++;
        n_checks++; if (zero !== 1'b1) $display("FAIL multu_2^32 zero: got %b want 1", zero); else n_pass++;
        drain();
    endtask

    task automatic test_divu();
        int cyc; bit rdy;
        issue(4'd14, 32'd100, 32'd7);
        wait_valid(cyc, rdy);
        n_checks++; if (cyc != 33) $display("FAIL divu latency: got %0d want 33", cyc); else n_pass++;
        n_checks++; if (result !== 32'd14) $display("FAIL divu quotient: got %0d want 14", result); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL divu remainder: got %0d want 2", hi); else n_pass++;
        n_checks++; if (div0 !== 1'b0) $display("FAIL divu div0: got %b want 0", div0); else n_pass++;
        drain();
        issue(4'd14, 32'hFFFF_FFFF, 32'h0001_0000);
        wait_valid(cyc, rdy);
        n_checks++; if ({result, hi} !== {32'h0000_FFFF, 32'h0000_FFFF}) $display("FAIL divu_big q/r: got %h/%h want 0000ffff/0000ffff", result, hi); else n_pass++;
        drain();
    endtask

    task automatic test_div0();
        int cyc; bit rdy;
        issue(4'd14, 32'd9, 32'd0);
        wait_valid(cyc, rdy);
        n_checks++; if (cyc != 1) $display("FAIL div0 latency: got %0d want 1", cyc); else n_pass++;
        n_checks++; if (div0 !== 1'b1) $display("FAIL div0 flag: got %b want 1", div0); else n_pass++;
        n_checks++; if (result !== 32'hFFFF_FFFF) $display("FAIL div0 result: got %h want ffffffff", result); else n_pass++;
        n_checks++; if (hi !== 32'd9) $display("FAIL div0 hi: got %h want 9", hi); else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        int cyc; bit rdy;
        int bad_cycles;
        issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_valid(cyc, rdy);
        // offer a competing op while stalled; it must be ignored
        alu_ctl = 4'd0; a = 32'h1; b = 32'h1; in_valid = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h8000_0000 ||
                hi !== 32'h0 || ovf !== 1'b1 || zero !== 1'b0) bad_cycles++;
        end
        in_valid = 1'b0;
        n_checks++; if (bad_cycles != 0) $display("FAIL stall stability: got %0d unstable cycles want 0", bad_cycles); else n_pass++;
        drain();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stall release out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stall release in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL flags cleared on transfer: ovf got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc; bit rdy;
        issue(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_valid(cyc, rdy);
        n_checks++; if (result !== 32'hF000_F000) $display("FAIL b2b and: got %h want f000f000", result); else n_pass++;
        drain();
        issue(4'd1, 32'h0F0F_0000, 32'h0000_00F0);
        wait_valid(cyc, rdy);
        n_checks++; if (cyc != 1) $display("FAIL b2b or latency: got %0d want 1", cyc); else n_pass++;
        n_checks++; if (result !== 32'h0F0F_00F0) $display("FAIL b2b or: got %h want 0f0f00f0", result); else n_pass++;
        drain();
    endtask

    task automatic test_reset_midop();
        int cyc; bit rdy;
        issue(4'd13, 32'h1234_5678, 32'h0000_0010);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({result, hi} !== 64'h0) $display("FAIL async reset result/hi: got %h/%h want 0/0", result, hi); else n_pass++;
        n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL async reset valid/ready: got %b want 01", {out_valid, in_ready}); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd2, 32'd2, 32'd3);
        wait_valid(cyc, rdy);
        n_checks++; if (cyc != 1) $display("FAIL post-reset add latency: got %0d want 1", cyc); else n_pass++;
        n_checks++; if (result !== 32'd5) $display("FAIL post-reset add: got %0d want 5", result); else n_pass++;
        drain();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_compare_logic();
        test_bad_op();
        test_multu();
        test_divu();
        test_div0();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
